// File: rtl/arkanoid_pkg.sv
// Shared types and widths for the Arkanoid game logic.
// GAME_CTRL_PAUSE_EN adds the PAUSE state encoding.
package arkanoid_pkg;

    localparam int unsigned LIVES_W = 2;
    localparam int unsigned LEVEL_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_DEAD  = 3'd3,
        ST_CLEAR = 3'd4,
`ifdef GAME_CTRL_PAUSE_EN
        ST_OVER  = 3'd5,
        ST_PAUSE = 3'd6
`else
        ST_OVER  = 3'd5
`endif
    } game_state_t;

endpackage

// File: rtl/edge_detect.sv
// One-bit rising-edge detector with a registered one-cycle pulse output.
module edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic din_q;
    logic rise_q;
    logic rise_d;

    // Rise when the input is high and its registered copy is still low.
    always_comb begin
        rise_d = din & ~din_q;
    end

    // Registered copy of the input and the detected pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            din_q  <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            din_q  <= din;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/game_ctrl.sv
// Arkanoid game sequencer: title, serve, play, death, stage-clear, game-over.
// GAME_CTRL_PAUSE_EN adds a PAUSE state toggled by start presses during play.
module game_ctrl
    import arkanoid_pkg::*;
#(
    parameter int unsigned LIVES       = 3,
    parameter int unsigned HOLD_FRAMES = 120
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               btn_start,
    input  logic               ball_lost,
    input  logic               blocks_clear,
    output logic               init,
    output logic               dead,
    output logic               run,
    output logic               serve,
    output logic [LIVES_W-1:0] lives,
    output logic [LEVEL_W-1:0] level
);

    localparam int unsigned CNT_W = $clog2(HOLD_FRAMES + 1);

    game_state_t        state_q, state_d;
    logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
    logic [LIVES_W-1:0] lives_q, lives_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               init_q, init_d;
    logic               dead_q, dead_d;
    logic               run_q, run_d;
    logic               serve_q, serve_d;
    logic               press;
    logic               hold_done;

    edge_detect u_start_edge (
        .clk   (clock),
        .rst_n (reset),
        .din   (btn_start),
        .rise  (press)
    );

    assign hold_done = frame_tick && (frame_cnt_q == CNT_W'(HOLD_FRAMES - 1));

    // Next state, counters and output decode of the next state.
    always_comb begin
        state_d     = state_q;
        frame_cnt_d = frame_cnt_q;
        lives_d     = lives_q;
        level_d     = level_q;

        unique case (state_q)
            ST_IDLE: begin
                if (press) begin
                    lives_d = LIVES_W'(LIVES);
                    level_d = '0;
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                if (press) state_d = ST_PLAY;
            end
            ST_PLAY: begin
                if (blocks_clear) begin
                    state_d = ST_CLEAR;
                end else if (ball_lost) begin
                    if (lives_q > LIVES_W'(1)) begin
                        lives_d = lives_q - LIVES_W'(1);
                        state_d = ST_DEAD;
                    end else begin
                        lives_d = '0;
                        state_d = ST_OVER;
                    end
                end
`ifdef GAME_CTRL_PAUSE_EN
                else if (press) begin
                    state_d = ST_PAUSE;
                end
`endif
            end
            ST_DEAD: begin
                if (hold_done) state_d = ST_SERVE;
            end
            ST_CLEAR: begin
                if (hold_done) begin
                    level_d = level_q + LEVEL_W'(1);
                    state_d = ST_SERVE;
                end
            end
            ST_OVER: begin
                if (press) state_d = ST_IDLE;
            end
`ifdef GAME_CTRL_PAUSE_EN
            ST_PAUSE: begin
                if (press) state_d = ST_PLAY;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Hold counter restarts on every state change; counts ticks only in DEAD/CLEAR.
        if (state_d != state_q) begin
            frame_cnt_d = '0;
        end else if (frame_tick && (state_q == ST_DEAD || state_q == ST_CLEAR)) begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end

        init_d  = (state_d == ST_IDLE) || (state_d == ST_CLEAR);
        dead_d  = (state_d == ST_DEAD) || (state_d == ST_OVER);
        run_d   = (state_d == ST_PLAY);
        serve_d = (state_d == ST_SERVE) && (state_q != ST_SERVE);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            frame_cnt_q <= '0;
            lives_q     <= LIVES_W'(LIVES);
            level_q     <= '0;
            init_q      <= 1'b1;
            dead_q      <= 1'b0;
            run_q       <= 1'b0;
            serve_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            init_q      <= init_d;
            dead_q      <= dead_d;
            run_q       <= run_d;
            serve_q     <= serve_d;
        end
    end

    assign init  = init_q;
    assign dead  = dead_q;
    assign run   = run_q;
    assign serve = serve_q;
    assign lives = lives_q;
    assign level = level_q;

endmodule

// File: doc/game_ctrl.md
# game_ctrl

Top-level game sequencer for the Arkanoid display pipeline. It tracks title, serve, play, death, stage-clear and game-over phases, and drives these signals:
- `init` and `dead` into the layer-priority RGB mux.
- Motion enables and serve requests to the ball, paddle and gift logic.
- The life and stage counters.

All sequencing advances on the per-frame tick from VGA timing and on start-button presses.

## Interface
- `LIVES`, 3: lives loaded at new game, range 1..3.
- `HOLD_FRAMES`, 120: frames the death flash and the stage-clear screen are held, ≥1.
- `clock` in 1: system clock.
- `reset` in 1: asynchronous, active-low reset.
- `frame_tick` in 1: one-cycle pulse per frame, at vblank start.
- `btn_start` in 1: start button level, already synchronized and debounced.
- `ball_lost` in 1: one-cycle pulse, ball passed paddle.
- `blocks_clear` in 1: level, no blocks remain.
- `init` out 1: title or stage-clear screen; background layer has priority.
- `dead` out 1: death or game-over; background layer has priority.
- `run` out 1: enables ball, gift and paddle motion.
- `serve` out 1: one-cycle pulse, reposition ball on paddle.
- `lives` out 2: remaining lives.
- `level` out 3: current stage.

## Operation
- **Start press:** a rising edge of `btn_start`, detected against a registered copy of the input. The registered copy resets to 0.
- **States:** IDLE, SERVE, PLAY, DEAD, CLEAR, OVER.
- **IDLE:** `init`=1. On a press, load `lives`=LIVES and `level`=0, then go to SERVE.
- **SERVE:** `run`=0, with the ball shown on the paddle. A press goes to PLAY.
- **PLAY:** `run`=1.
  - `blocks_clear`=1 goes to CLEAR. It takes precedence over a same-cycle `ball_lost`.
  - Otherwise, `ball_lost` with `lives`>1 decrements `lives` and goes to DEAD.
  - Otherwise, `ball_lost` with `lives`==1 sets `lives`=0 and goes to OVER.
- **DEAD:** `dead`=1. Goes to SERVE after HOLD_FRAMES `frame_tick` pulses.
- **CLEAR:** `init`=1. Goes to SERVE after HOLD_FRAMES ticks. `level` increments on exit and wraps 7→0.
- **OVER:** `dead`=1 until a press, then goes to IDLE. `lives` holds at 0.
- **Inputs ignored by state:**
  - `ball_lost` and `blocks_clear` outside PLAY.
  - Presses in DEAD and CLEAR.
- **Frame counter:**
  - Width `$clog2(HOLD_FRAMES+1)`.
  - Cleared on every state change.
  - Increments only on `frame_tick` while in DEAD or CLEAR.
  - The exit condition is `frame_tick` with count == HOLD_FRAMES-1.
- **`serve`:** high for exactly the first cycle SERVE is occupied, on every entry.
- **Output values:** `init`, `dead` and `run` are pure decodes of the registered state, so each is a glitch-free flop output. Exactly one of them, or none, is high in any state:

  | State | `init` | `dead` | `run` |
  |---|---|---|---|
  | IDLE, CLEAR | 1 | 0 | 0 |
  | DEAD, OVER | 0 | 1 | 0 |
  | PLAY | 0 | 0 | 1 |
  | SERVE | 0 | 0 | 0 |

## Timing
- **Reset:** asserting `reset` low forces the following immediately and asynchronously, including mid-game:
  - state IDLE, frame counter 0;
  - `init`=1, `dead`=0, `run`=0, `serve`=0;
  - `lives`=LIVES, `level`=0.
- **Input-to-output latency:** an event sampled at edge N changes the state and outputs after edge N. One cycle, no combinational paths.
- **Press latency:** a `btn_start` rise sampled at edge N is detected at edge N+1 and acts then. Two edges from input to output change.
- **Hold duration:** DEAD and CLEAR last exactly HOLD_FRAMES ticks.
  - The state exits on the cycle after the last tick.
  - A tick coinciding with the entry edge is not counted.

## Configuration
- **`GAME_CTRL_PAUSE_EN`** defined: adds state PAUSE.
  - A press in PLAY goes to PAUSE, with `run`=0 and all outputs otherwise held.
  - A press in PAUSE returns to PLAY.
  - `ball_lost` and `blocks_clear` are ignored in PAUSE.
- **Undefined:** presses in PLAY are ignored, and the PAUSE encoding is absent.

## Structure
- **Shared package `arkanoid_pkg`:** the state enum `game_state_t` and the lives and level widths. The bus-facing modules use the same width constants.
- **Sub-module `edge_detect`:** one-bit rising-edge detector with asynchronous active-low reset, reusable for the other buttons.

## Test plan
- **Reset and new game:** reset low, then a press → `init`=1 during reset; after the press, `serve` pulses once, `lives`=3, `level`=0, `run`=0.
- **Lose one life:** SERVE, press, then `ball_lost` in PLAY → `lives`=2, `dead`=1 for exactly 120 ticks, then SERVE with a `serve` pulse.
- **Stage clear wins a tie:** `ball_lost` and `blocks_clear` in the same cycle → CLEAR, `lives` unchanged, `level` 0→1 after 120 ticks. Seven more clears wrap `level` to 0.
- **Game over:** `lives`=1 and `ball_lost` → OVER, `dead`=1, `lives`=0; a press → IDLE, `init`=1.
- **Reset mid-hold:** reset in DEAD at tick 50 → immediate IDLE, counter 0, `lives`=3.
- **Pause (`GAME_CTRL_PAUSE_EN` defined):** press in PLAY → `run`=0, and a `ball_lost` pulse there is ignored; a second press → `run`=1.
